// File: rtl/mem_arbiter_pkg.sv
// Shared widths, state/owner encodings and default streak limit for mem_arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ADDR           = 16;
  localparam int unsigned W_OPR          = 32;
  localparam int unsigned STREAK_DEFAULT = 4;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  localparam logic [0:0] OwnIf = 1'b0;
  localparam logic [0:0] OwnLs = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter onto one synchronous RAM port; one access per two cycles.
// Define ARB_STARVE_GUARD_EN to let a waiting fetch win after STREAK load/store grants.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STREAK = STREAK_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req_i,
  input  logic [ADDR-1:0]  if_addr_i,
  output logic             if_ack_o,
  output logic [W_OPR-1:0] if_data_o,
  input  logic             ls_req_i,
  input  logic             ls_write_i,
  input  logic [ADDR-1:0]  ls_addr_i,
  input  logic [W_OPR-1:0] ls_wdata_i,
  output logic             ls_ack_o,
  output logic [W_OPR-1:0] ls_rdata_o,
  output logic             stall_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [W_OPR-1:0] mem_wdata_o,
  input  logic [W_OPR-1:0] mem_rdata_i
);

  logic [0:0] state_q, state_d;
  logic [0:0] owner_q, owner_d;
  logic       store_q, store_d;
  logic       grant_if, grant_ls;
  logic       starve;
  logic       in_access;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STREAK + 1) > 0 ? $clog2(STREAK + 1) : 1;

  logic [CntW-1:0] streak_q, streak_d;

  assign starve = if_req_i && (streak_q == CntW'(STREAK));

  always_comb begin
    streak_d = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_ls && if_req_i) begin
      streak_d = streak_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign starve = 1'b0;
`endif

  // Grants are only made from IDLE; load/store wins unless the starvation guard trips.
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (state_q == StIdle) begin
      if (ls_req_i && !starve) begin
        grant_ls = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = StIdle;
    owner_d = owner_q;
    store_d = store_q;
    if (grant_ls) begin
      state_d = StAccess;
      owner_d = OwnLs;
      store_d = ls_write_i;
    end else if (grant_if) begin
      state_d = StAccess;
      owner_d = OwnIf;
      store_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= OwnIf;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      store_q <= store_d;
    end
  end

  // Outputs are gated by reset so nothing escapes while reset is held.
  assign in_access = (state_q == StAccess) && !reset;

  always_comb begin
    if_ack_o    = in_access && (owner_q == OwnIf);
    ls_ack_o    = in_access && (owner_q == OwnLs);
    if_data_o   = if_ack_o ? mem_rdata_i : '0;
    ls_rdata_o  = (ls_ack_o && !store_q) ? mem_rdata_i : '0;
    mem_en_o    = !reset && (grant_if || grant_ls);
    mem_we_o    = !reset && grant_ls && ls_write_i;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (!reset && grant_ls) begin
      mem_addr_o = ls_addr_i;
      if (ls_write_i) begin
        mem_wdata_o = ls_wdata_i;
      end
    end else if (!reset && grant_if) begin
      mem_addr_o = if_addr_i;
    end
    stall_o = ls_req_i && !ls_ack_o;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic vs a model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

`ifdef ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif
  localparam int Streak = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_req_i, ls_req_i, ls_write_i;
  logic [ADDR-1:0]  if_addr_i, ls_addr_i;
  logic [W_OPR-1:0] ls_wdata_i;
  logic             if_ack_o, ls_ack_o, stall_o, mem_en_o, mem_we_o;
  logic [W_OPR-1:0] if_data_o, ls_rdata_o, mem_wdata_o, mem_rdata_i;
  logic [ADDR-1:0]  mem_addr_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STREAK(Streak)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .if_req_i   (if_req_i),
    .if_addr_i  (if_addr_i),
    .if_ack_o   (if_ack_o),
    .if_data_o  (if_data_o),
    .ls_req_i   (ls_req_i),
    .ls_write_i (ls_write_i),
    .ls_addr_i  (ls_addr_i),
    .ls_wdata_i (ls_wdata_i),
    .ls_ack_o   (ls_ack_o),
    .ls_rdata_o (ls_rdata_o),
    .stall_o    (stall_o),
    .mem_en_o   (mem_en_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  function automatic logic [W_OPR-1:0] init_val(input logic [ADDR-1:0] a);
    if (a == 16'h0010) return 32'h1234_5678;
    return {a, ~a};
  endfunction

  // Synchronous read-first RAM behind the arbiter.
  logic [W_OPR-1:0] ram    [65536];
  bit               ram_wr [65536];
  always @(posedge clk) begin
    if (mem_en_o) begin
      mem_rdata_i <= ram_wr[mem_addr_o] ? ram[mem_addr_o] : init_val(mem_addr_o);
      if (mem_we_o) begin
        ram[mem_addr_o]    <= mem_wdata_o;
        ram_wr[mem_addr_o] <= 1'b1;
      end
    end
  end

  // Reference model: one pending access, who was served, and the guard's grant count.
  logic [W_OPR-1:0] ref_val [65536];
  bit               ref_wr  [65536];
  bit               m_busy = 0, m_owner_ls = 0, m_store = 0;
  logic [W_OPR-1:0] m_rd = '0;
  int               m_streak = 0;

  logic             o_if_ack, o_ls_ack, o_en, o_we, o_stall;
  logic [ADDR-1:0]  o_addr;
  logic [W_OPR-1:0] o_wdata, o_if_data, o_ls_data;
  bit               e_ifa_last, e_lsa_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W_OPR-1:0] ref_rd(input logic [ADDR-1:0] a);
    return ref_wr[a] ? ref_val[a] : init_val(a);
  endfunction

  // One clock: compare outputs mid-cycle, step the model, return 1ns after the next edge.
  task automatic do_cycle();
    int               who;
    bit               e_ifa, e_lsa, e_en, e_we, e_stall;
    logic [ADDR-1:0]  e_addr;
    logic [W_OPR-1:0] e_wd, e_ifd, e_lsd;
    @(negedge clk);
    who = 0; e_ifa = 0; e_lsa = 0; e_en = 0; e_we = 0;
    e_addr = '0; e_wd = '0; e_ifd = '0; e_lsd = '0;
    if (!reset) begin
      if (m_busy) begin
        if (m_owner_ls) begin
          e_lsa = 1;
          e_lsd = m_store ? '0 : m_rd;
        end else begin
          e_ifa = 1;
          e_ifd = m_rd;
        end
      end else if (ls_req_i && !(Guard && if_req_i && m_streak == Streak)) begin
        who = 2;
      end else if (if_req_i) begin
        who = 1;
      end
    end
    if (who == 2) begin
      e_en = 1; e_we = ls_write_i; e_addr = ls_addr_i;
      e_wd = ls_write_i ? ls_wdata_i : '0;
    end else if (who == 1) begin
      e_en = 1; e_addr = if_addr_i;
    end
    e_stall = ls_req_i && !e_lsa;

    o_if_ack = if_ack_o; o_ls_ack = ls_ack_o; o_en = mem_en_o; o_we = mem_we_o;
    o_stall = stall_o; o_addr = mem_addr_o; o_wdata = mem_wdata_o;
    o_if_data = if_data_o; o_ls_data = ls_rdata_o;
    check("ctl{ifack,lsack,en,we,stall}", 64'({o_if_ack, o_ls_ack, o_en, o_we, o_stall}),
          64'({e_ifa, e_lsa, e_en, e_we, e_stall}));
    check("mem_addr", 64'(o_addr), 64'(e_addr));
    check("mem_wdata", 64'(o_wdata), 64'(e_wd));
    check("if_data", 64'(o_if_data), 64'(e_ifd));
    check("ls_rdata", 64'(o_ls_data), 64'(e_lsd));
    e_ifa_last = e_ifa;
    e_lsa_last = e_lsa;

    if (reset) begin
      m_busy = 0; m_streak = 0;
    end else if (m_busy) begin
      m_busy = 0;
    end else if (who != 0) begin
      m_busy     = 1;
      m_owner_ls = (who == 2);
      m_store    = (who == 2) && ls_write_i;
      m_rd       = ref_rd(e_addr);
      if (m_store) begin
        ref_val[e_addr] = ls_wdata_i;
        ref_wr[e_addr]  = 1;
      end
      if (who == 1) m_streak = 0;
      else if (if_req_i) m_streak++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int ls_before, ls_after, if_seen;
    reset = 1; if_req_i = 1; ls_req_i = 1; ls_write_i = 1;
    if_addr_i = 16'h0004; ls_addr_i = 16'h0008; ls_wdata_i = 32'hAAAA_5555;
    @(posedge clk); #1;
    do_cycle();
    do_cycle();
    check("rst_outputs_zero", 64'({o_if_ack, o_ls_ack, o_en, o_we, o_addr, o_wdata}), 64'(0));
    reset = 0; if_req_i = 0; ls_req_i = 0; ls_write_i = 0;
    do_cycle();
    check("idle_no_en", 64'(o_en), 64'(0));

    // Fetch only.
    if_req_i = 1; if_addr_i = 16'h0010;
    do_cycle();
    check("fetch_grant_en", 64'(o_en), 64'(1));
    check("fetch_grant_addr", 64'(o_addr), 64'h0010);
    do_cycle();
    check("fetch_ack", 64'(o_if_ack), 64'(1));
    check("fetch_data", 64'(o_if_data), 64'h1234_5678);
    if_req_i = 0;

    // Store, then load it back.
    ls_req_i = 1; ls_write_i = 1; ls_addr_i = 16'h0200; ls_wdata_i = 32'hDEAD_BEEF;
    do_cycle();
    check("store_we_wdata_stall", 64'({o_we, o_stall, o_wdata}), {31'd0, 1'b1, 1'b1, 32'hDEAD_BEEF});
    do_cycle();
    check("store_ack_rdata_stall", 64'({o_ls_ack, o_stall, o_ls_data}), {31'd0, 1'b1, 1'b0, 32'd0});
    ls_write_i = 0;
    do_cycle();
    do_cycle();
    check("load_back", 64'(o_ls_data), 64'hDEAD_BEEF);
    ls_req_i = 0;

    // Simultaneous requests: LS first, then IF.
    if_req_i = 1; ls_req_i = 1; ls_addr_i = 16'h0200; if_addr_i = 16'h0010;
    do_cycle();
    check("both_n_grant_addr", 64'(o_addr), 64'h0200);
    do_cycle();
    check("both_n1_acks", 64'({o_ls_ack, o_if_ack}), 64'b10);
    ls_req_i = 0;
    do_cycle();
    check("both_n2_if_grant", 64'({o_en, o_addr}), {47'd0, 1'b1, 16'h0010});
    do_cycle();
    check("both_n3_if_ack", 64'(o_if_ack), 64'(1));
    if_req_i = 0;
    do_cycle();

    // Load/store held continuously while a fetch waits.
    ls_req_i = 1; ls_write_i = 0; ls_addr_i = 16'h0003; if_req_i = 1; if_addr_i = 16'h0007;
    ls_before = 0; ls_after = 0; if_seen = 0;
    for (int c = 0; c < 24; c++) begin
      do_cycle();
      if (o_if_ack) begin
        if_seen++;
        if_req_i = 0;
      end
      if (o_ls_ack) begin
        if (if_seen > 0) ls_after++;
        else ls_before++;
      end
      if (!Guard && c == 19) check("noguard_no_if_ack_20", 64'(if_seen), 64'(0));
    end
    if (Guard) begin
      check("guard_ls_before_if", 64'(ls_before), 64'(Streak));
      check("guard_if_acks", 64'(if_seen), 64'(1));
      check("guard_ls_resumes", 64'(ls_after > 0), 64'(1));
    end else begin
      check("noguard_ls_acks", 64'(ls_before), 64'(12));
    end
    if_req_i = 0; ls_req_i = 0;
    do_cycle();
    do_cycle();

    // Reset during ACCESS.
    ls_req_i = 1; ls_addr_i = 16'h0010;
    do_cycle();
    reset = 1;
    do_cycle();
    check("rst_access_no_ack", 64'({o_ls_ack, o_if_ack}), 64'(0));
    reset = 0; ls_req_i = 0;
    do_cycle();
    check("post_rst_outputs_zero",
          64'({o_if_ack, o_ls_ack, o_en, o_we, o_stall, o_addr, o_wdata, o_if_data}), 64'(0));
    if_req_i = 1; if_addr_i = 16'h0002;
    do_cycle();
    check("post_rst_idle_grant", 64'(o_en), 64'(1));
    do_cycle();
    if_req_i = 0;

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!if_req_i || e_ifa_last) begin
        if_req_i  = ($urandom_range(0, 2) != 0);
        if_addr_i = 16'($urandom_range(0, 15));
      end
      if (!ls_req_i || e_lsa_last) begin
        ls_req_i   = ($urandom_range(0, 2) != 0);
        ls_write_i = $urandom_range(0, 1) != 0;
        ls_addr_i  = 16'($urandom_range(0, 15));
        ls_wdata_i = $urandom;
      end
      do_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STREAK, default 4: max consecutive load/store grants while a fetch request waits.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req_i  input  1  fetch read request, held until if_ack_o.
REQ-005 if_addr_i  input  ADDR  fetch word address, stable while if_req_i is high.
REQ-006 if_ack_o  output  1  one-cycle fetch completion pulse.
REQ-007 if_data_o  output  W_OPR  fetch read data, valid when if_ack_o is high.
REQ-008 ls_req_i  input  1  load/store request, held until ls_ack_o.
REQ-009 ls_write_i  input  1  1 = store, 0 = load.
REQ-010 ls_addr_i  input  ADDR  load/store address.
REQ-011 ls_wdata_i  input  W_OPR  store data.
REQ-012 ls_ack_o  output  1  one-cycle load/store completion pulse.
REQ-013 ls_rdata_o  output  W_OPR  load data, valid when ls_ack_o is high.
REQ-014 stall_o  output  1  pipeline stall, equal to ls_req_i & ~ls_ack_o.
REQ-015 mem_en_o / mem_we_o  output  1 each  memory enable and write enable.
REQ-016 mem_addr_o  output  ADDR  memory address.
REQ-017 mem_wdata_o  output  W_OPR  memory write data.
REQ-018 mem_rdata_i  input  W_OPR  synchronous RAM read data, valid one cycle after mem_en_o.

Function
REQ-019 FSM states: IDLE and ACCESS; owner register: IF or LS.
REQ-020 IDLE, no requests: mem_en_o=0 and the FSM stays in IDLE.
REQ-021 IDLE, any request: grant in the same cycle; drive mem_en_o=1 and the granted requester's addr (plus we/wdata for LS); next state ACCESS; owner latched.
REQ-022 Only LS drives mem_we_o=1, and only when ls_write_i=1; fetch is read-only.
REQ-023 Priority: LS wins over IF, except under the starvation-guard rule (REQ-033).
REQ-024 ACCESS: assert the owner's ack for exactly one cycle; mem_en_o=0; next state IDLE unconditionally.
REQ-025 Consequences of REQ-024: fixed latency of 1 cycle from grant to ack; maximum throughput of one access per 2 cycles.
REQ-026 ACCESS, load or fetch: route mem_rdata_i to the owner's data output; the non-owner's data output = 0.
REQ-027 ACCESS, store: ls_rdata_o = 0.
REQ-028 A request still high in the cycle after its ack is treated as a new request.
REQ-029 Requests arriving during ACCESS are arbitered in the following IDLE cycle, never dropped.
REQ-030 Simultaneous IF and LS requests in IDLE: exactly one grant; the loser's ack stays 0 and its req must remain held.

Reset
REQ-031 While reset=1 at posedge clk, all of the following SHALL hold:
- state = IDLE and owner = IF;
- streak counter = 0;
- if_ack_o, ls_ack_o, mem_en_o, mem_we_o = 0;
- if_data_o, ls_rdata_o, mem_addr_o, mem_wdata_o = 0.
REQ-032 Reset asserted during ACCESS: no ack is issued; a store already presented to memory is not undone.

Configuration
REQ-033 With ARB_STARVE_GUARD_EN defined:
- a log2(STREAK+1)-bit streak counter increments on each LS grant made while if_req_i=1;
- the counter clears on every IF grant;
- when streak == STREAK and if_req_i=1, IF wins over LS.
REQ-034 Without ARB_STARVE_GUARD_EN: strict LS priority and no counter logic.

Structure
REQ-035 ADDR and W_OPR come from the shared include/params.v.
REQ-036 State encodings and STREAK default are added to include/params.v.
REQ-037 No sub-modules: the FSM, counter and output muxing are one module.

Verification
REQ-038 IF only, if_addr_i=0x0010, mem_rdata_i=0x12345678 in the next cycle: mem_en_o=1 with mem_addr_o=0x0010 in cycle N; if_ack_o=1 with if_data_o=0x12345678 in N+1.
REQ-039 LS store, ls_addr_i=0x0200, ls_wdata_i=0xDEADBEEF: mem_we_o=1 and mem_wdata_o=0xDEADBEEF in N; ls_ack_o=1 with ls_rdata_o=0 in N+1; stall_o=1 in N and 0 in N+1.
REQ-040 IF and LS requesting in the same cycle: LS is granted first (ls_ack_o at N+1), IF at N+2 (if_ack_o at N+3).
REQ-041 Guard on, STREAK=4, LS held continuously with IF pending: 4 LS acks, then 1 IF ack, then LS resumes.
REQ-042 Guard off, same stimulus as REQ-041: no if_ack_o for 20 cycles.
REQ-043 reset=1 pulsed during ACCESS: no ack is issued, all outputs = 0 in the next cycle, FSM is in IDLE.
